// File: rtl/unlock_code_tx.sv
`default_nettype none
// ============================================================================
// unlock_code_tx : shifts a parallel unlock code MSB-first to the lock FSM,
//                  then waits for the lock's unlock indication or a timeout.
// Revision: 1.0
// ============================================================================
module unlock_code_tx #(
  parameter int CODE_W     = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic              resp_val,
  input  logic              resp_data,
  output logic              ser_val,
  output logic              ser_data,
  output logic              busy,
  output logic              done,
  output logic              unlocked,
  output logic              timeout_err
);

  localparam int BW = $clog2(CODE_W + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    GAP       = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CODE_W-1:0] shift_reg, shift_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [GW-1:0]     gap_cnt, gap_cnt_n;
  logic [TW-1:0]     timer, timer_n;
  logic              unlocked_n, timeout_n;
  logic              ser_val_n, ser_data_n, busy_n, done_n;

  always_comb begin
    state_n    = state;
    shift_n    = shift_reg;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    timer_n    = timer;
    unlocked_n = unlocked;
    timeout_n  = timeout_err;

    case (state)
      IDLE: begin
        if (start) begin
          shift_n    = code;
          bit_cnt_n  = '0;
          unlocked_n = 1'b0;
          timeout_n  = 1'b0;
          state_n    = SEND;
        end
      end
      SEND: begin
        shift_n   = shift_reg << 1;
        bit_cnt_n = bit_cnt + BW'(1);
        if (bit_cnt == BW'(CODE_W - 1)) begin
          timer_n = '0;
          state_n = WAIT_RESP;
        end else if (GAP_CYCLES > 0) begin
          gap_cnt_n = '0;
          state_n   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_n = SEND;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      WAIT_RESP: begin
        // A response only counts once the whole code has been shifted out.
        if (resp_val && resp_data) begin
          unlocked_n = 1'b1;
          state_n    = DONE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_n = 1'b1;
          state_n   = DONE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    ser_val_n  = (state_n == SEND);
    ser_data_n = (state_n == SEND) ? shift_n[CODE_W-1] : 1'b0;
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      timer       <= '0;
      unlocked    <= 1'b0;
      timeout_err <= 1'b0;
      ser_val     <= 1'b0;
      ser_data    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      shift_reg   <= shift_n;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      timer       <= timer_n;
      unlocked    <= unlocked_n;
      timeout_err <= timeout_n;
      ser_val     <= ser_val_n;
      ser_data    <= ser_data_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule
`default_nettype wire
